debug_loader: RTL and testbench

//  Single-clock program loader; the driving end of the core's debug program-load port (DEBUG_SIG/addr/instr/clk_debug).

---
 rtl/loader_pkg.sv | 22 ++
 rtl/loader_timeout.sv | 34 +++
 rtl/debug_loader.sv | 182 ++++++++++++++++++
 tb/tb_debug_loader.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// Shared types and constants for the debug program loader.
package loader_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ADDR  = 3'd1,
    COUNT = 3'd2,
    DATA  = 3'd3,
    WRITE = 3'd4,
    CSUM  = 3'd5,
    DONE  = 3'd6,
    ERR   = 3'd7
  } loader_state_t;

  localparam logic [7:0] LOADER_MAGIC = 8'hA5;

  // True while a frame is being received (core is held and the timeout runs).
  function automatic logic loader_in_frame(input loader_state_t s);
    return (s inside {ADDR, COUNT, DATA, WRITE, CSUM});
  endfunction

endpackage

// File: rtl/loader_timeout.sv
// Idle-gap watchdog: loadable down-counter. clear reloads it, enable counts
// down, expired flags the cycle in which the count would go past zero.
// TIMEOUT_CYCLES == 0 disables the watchdog entirely.
module loader_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic nrst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic        TIMEOUT_ON = (TIMEOUT_CYCLES != 32'd0);
  localparam logic [31:0] LOAD_VALUE = TIMEOUT_ON ? 32'(TIMEOUT_CYCLES - 32'd1) : 32'd0;

  logic [31:0] count_r;

  // Reload on clear, otherwise count idle cycles down towards zero.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      count_r <= LOAD_VALUE;
    end else if (clear) begin
      count_r <= LOAD_VALUE;
    end else if (enable && (count_r != 32'd0)) begin
      count_r <= count_r - 32'd1;
    end else begin
      count_r <= count_r;
    end
  end

  assign expired = TIMEOUT_ON & enable & (count_r == 32'd0);

endmodule

// File: rtl/debug_loader.sv
// Program loader: turns a byte stream (MAGIC | base | count | words [| csum])
// into one-cycle instruction-memory write strobes on the core debug port,
// holding the core in reset while a frame is in progress.
// Optional feature macro: DEBUG_LOADER_CHECKSUM_EN adds a trailing XOR
// checksum byte covering every byte after MAGIC.
module debug_loader
  import loader_pkg::*;
#(
  parameter logic [7:0]  MAGIC          = LOADER_MAGIC,
  parameter int unsigned MAX_WORDS      = 4096,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        debug_sig,
  output logic [31:0] debug_addr,
  output logic [31:0] debug_instr,
  output logic        debug_clk,
  output logic        core_nrst,
  output logic        done,
  output logic        error
);

  localparam logic [31:0] MAX_WORDS_W = 32'(MAX_WORDS);

`ifdef DEBUG_LOADER_CHECKSUM_EN
  localparam loader_state_t END_STATE = CSUM;
`else
  localparam loader_state_t END_STATE = DONE;
`endif

  loader_state_t state_r, next_state_s;
  logic [1:0]    byte_cnt_r;
  logic [23:0]   count_r;       // first three count bytes; the fourth arrives on rx_data
  logic [31:0]   remaining_r;
  logic [31:0]   debug_addr_r, debug_instr_r;
  logic          rx_ready_r, debug_sig_r, debug_clk_r, core_nrst_r, done_r, error_r;
`ifdef DEBUG_LOADER_CHECKSUM_EN
  logic [7:0]    csum_r;
`endif

  logic          xfer_s, last_byte_s, in_frame_s, start_s, expired_s;
  logic          clear_s, enable_s;
  logic [31:0]   n_word_s;

  assign xfer_s      = rx_valid & rx_ready_r;
  assign last_byte_s = xfer_s & (byte_cnt_r == 2'd3);
  assign in_frame_s  = loader_in_frame(state_r);
  assign start_s     = xfer_s & (rx_data == MAGIC) & ~in_frame_s;
  assign n_word_s    = {rx_data, count_r};

  // Any transfer, or being outside a frame, restarts the idle-gap watchdog.
  assign clear_s  = ~in_frame_s | xfer_s;
  assign enable_s = in_frame_s & ~xfer_s;

  loader_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk),
    .nrst    (nrst),
    .clear   (clear_s),
    .enable  (enable_s),
    .expired (expired_s)
  );

  // Next-state decision; a watchdog expiry wins in every in-frame state.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE, DONE, ERR: begin
        if (start_s) next_state_s = ADDR;
        else         next_state_s = state_r;
      end
      ADDR: begin
        // base byte 0 sits in debug_addr_r[15:8] when the 4th byte arrives
        if (expired_s)        next_state_s = ERR;
        else if (last_byte_s) next_state_s = (debug_addr_r[9:8] != 2'b00) ? ERR : COUNT;
        else                  next_state_s = state_r;
      end
      COUNT: begin
        if (expired_s)                     next_state_s = ERR;
        else if (!last_byte_s)             next_state_s = state_r;
        else if (n_word_s > MAX_WORDS_W)   next_state_s = ERR;
        else if (n_word_s == 32'd0)        next_state_s = END_STATE;
        else                               next_state_s = DATA;
      end
      DATA: begin
        if (expired_s)        next_state_s = ERR;
        else if (last_byte_s) next_state_s = WRITE;
        else                  next_state_s = state_r;
      end
      WRITE: begin
        if (expired_s)                   next_state_s = ERR;
        else if (remaining_r == 32'd1)   next_state_s = END_STATE;
        else                             next_state_s = DATA;
      end
`ifdef DEBUG_LOADER_CHECKSUM_EN
      CSUM: begin
        if (expired_s)   next_state_s = ERR;
        else if (xfer_s) next_state_s = (rx_data == csum_r) ? DONE : ERR;
        else             next_state_s = state_r;
      end
`endif
      default: next_state_s = ERR;
    endcase
  end

  // State, datapath and registered port values, all derived from next state.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_r       <= IDLE;
      byte_cnt_r    <= 2'd0;
      count_r       <= 24'd0;
      remaining_r   <= 32'd0;
      debug_addr_r  <= 32'd0;
      debug_instr_r <= 32'd0;
      rx_ready_r    <= 1'b1;
      debug_sig_r   <= 1'b0;
      debug_clk_r   <= 1'b0;
      core_nrst_r   <= 1'b0;
      done_r        <= 1'b0;
      error_r       <= 1'b0;
`ifdef DEBUG_LOADER_CHECKSUM_EN
      csum_r        <= 8'd0;
`endif
    end else begin
      state_r     <= next_state_s;
      rx_ready_r  <= (next_state_s != WRITE);
      debug_clk_r <= (next_state_s == WRITE);
      debug_sig_r <= loader_in_frame(next_state_s);
      core_nrst_r <= (next_state_s == DONE);
      done_r      <= (next_state_s == DONE);
      error_r     <= (next_state_s == ERR);

      if (start_s) begin
        byte_cnt_r <= 2'd0;
`ifdef DEBUG_LOADER_CHECKSUM_EN
        csum_r     <= 8'd0;
`endif
      end else if (xfer_s) begin
        byte_cnt_r <= byte_cnt_r + 2'd1;
`ifdef DEBUG_LOADER_CHECKSUM_EN
        csum_r     <= csum_r ^ rx_data;
`endif
      end

      // Little-endian assembly: each new byte enters at the top and shifts down.
      case (state_r)
        ADDR: begin
          if (xfer_s) debug_addr_r <= {rx_data, debug_addr_r[31:8]};
        end
        COUNT: begin
          if (xfer_s)      count_r     <= {rx_data, count_r[23:8]};
          if (last_byte_s) remaining_r <= n_word_s;
        end
        DATA: begin
          if (xfer_s) debug_instr_r <= {rx_data, debug_instr_r[31:8]};
        end
        WRITE: begin
          debug_addr_r <= debug_addr_r + 32'd4;
          remaining_r  <= remaining_r - 32'd1;
        end
        default: begin
          remaining_r <= remaining_r;
        end
      endcase
    end
  end

  assign rx_ready    = rx_ready_r;
  assign debug_sig   = debug_sig_r;
  assign debug_addr  = debug_addr_r;
  assign debug_instr = debug_instr_r;
  assign debug_clk   = debug_clk_r;
  assign core_nrst   = core_nrst_r;
  assign done        = done_r;
  assign error       = error_r;

endmodule

// File: tb/tb_debug_loader.sv
// Self-checking bench for debug_loader: directed frames plus randomized frames,
// each compared against a frame-level reference model.
module tb_debug_loader;

  typedef logic [7:0]  bq_t[$];
  typedef logic [31:0] wq_t[$];

  localparam int unsigned MAXW = 4096;

  logic        clk = 1'b0;
  logic        nrst = 1'b1;
  logic [7:0]  rx_data = 8'd0;
  logic        rx_valid = 1'b0;
  logic        rx_ready, debug_sig, debug_clk, core_nrst, done, error;
  logic [31:0] debug_addr, debug_instr;

  int checks = 0;
  int failures = 0;

  logic [31:0] got_addr[$];
  logic [31:0] got_instr[$];
  bit          mon_en = 1'b0;

  always #5 clk = ~clk;

  debug_loader #(
    .MAX_WORDS      (MAXW),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk         (clk),
    .nrst        (nrst),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .debug_sig   (debug_sig),
    .debug_addr  (debug_addr),
    .debug_instr (debug_instr),
    .debug_clk   (debug_clk),
    .core_nrst   (core_nrst),
    .done        (done),
    .error       (error)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Strobe capture; the loader may only refuse bytes during a write strobe.
  always @(negedge clk) begin
    if (mon_en) begin
      if (debug_clk === 1'b1) begin
        got_addr.push_back(debug_addr);
        got_instr.push_back(debug_instr);
      end
      check("ready_vs_strobe", {31'd0, rx_ready}, {31'd0, ~debug_clk});
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rx_ready"},  {31'd0, rx_ready},  32'd1);
    check({tag, "_debug_sig"}, {31'd0, debug_sig}, 32'd0);
    check({tag, "_addr"},      debug_addr,         32'd0);
    check({tag, "_instr"},     debug_instr,        32'd0);
    check({tag, "_debug_clk"}, {31'd0, debug_clk}, 32'd0);
    check({tag, "_core_nrst"}, {31'd0, core_nrst}, 32'd0);
    check({tag, "_done"},      {31'd0, done},      32'd0);
    check({tag, "_error"},     {31'd0, error},     32'd0);
  endtask

  // Called at a negedge; returns at the negedge following the accepting posedge.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int guard;
    if (gap > 0) begin
      rx_valid = 1'b0;
      repeat (gap) @(negedge clk);
    end
    rx_data  = b;
    rx_valid = 1'b1;
    guard    = 0;
    while (rx_ready !== 1'b1 && guard < 8) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 8) check("ready_wait_timeout", {31'd0, rx_ready}, 32'd1);
    @(negedge clk);
  endtask

  task automatic send_bytes(input bq_t f, input int max_gap);
    foreach (f[i]) send_byte(f[i], (max_gap == 0) ? 0 : int'($urandom_range(max_gap, 0)));
    rx_valid = 1'b0;
  endtask

  function automatic bq_t build_frame(input logic [31:0] base, input logic [31:0] n, input wq_t words);
    bq_t f;
    logic [7:0] x;
    f.push_back(8'hA5);
    for (int i = 0; i < 4; i++) f.push_back(base[8*i +: 8]);
    for (int i = 0; i < 4; i++) f.push_back(n[8*i +: 8]);
    foreach (words[w]) for (int i = 0; i < 4; i++) f.push_back(words[w][8*i +: 8]);
`ifdef DEBUG_LOADER_CHECKSUM_EN
    x = 8'd0;
    for (int i = 1; i < f.size(); i++) x = x ^ f[i];
    f.push_back(x);
`else
    x = 8'd0;
`endif
    return f;
  endfunction

  // Reference: parse the frame from its byte list and compare outcome + strobes.
  task automatic check_frame(input string tag, input bq_t f);
    logic [31:0] base, n;
    logic [7:0]  x;
    bit          err;
    wq_t         exp_a, exp_w;
    int          k;
    repeat (4) @(negedge clk);
    base = {f[4], f[3], f[2], f[1]};
    err  = 1'b0;
    if ((base % 4) != 0) begin
      err = 1'b1;
    end else begin
      n = {f[8], f[7], f[6], f[5]};
      if (n > MAXW) begin
        err = 1'b1;
      end else begin
        for (int i = 0; i < int'(n); i++) begin
          exp_a.push_back(base + 32'(4 * i));
          exp_w.push_back({f[12+4*i], f[11+4*i], f[10+4*i], f[9+4*i]});
        end
`ifdef DEBUG_LOADER_CHECKSUM_EN
        x = 8'd0;
        for (int i = 1; i < 9 + 4 * int'(n); i++) x = x ^ f[i];
        if (x != f[9 + 4 * int'(n)]) err = 1'b1;
`else
        x = 8'd0;
`endif
      end
    end
    check({tag, "_nstrobes"}, 32'(got_addr.size()), 32'(exp_a.size()));
    k = (got_addr.size() < exp_a.size()) ? got_addr.size() : exp_a.size();
    for (int i = 0; i < k; i++) begin
      check({tag, "_addr"},  got_addr[i],  exp_a[i]);
      check({tag, "_instr"}, got_instr[i], exp_w[i]);
    end
    check({tag, "_done"},      {31'd0, done},      {31'd0, ~err});
    check({tag, "_error"},     {31'd0, error},     {31'd0, err});
    check({tag, "_core_nrst"}, {31'd0, core_nrst}, {31'd0, ~err});
    check({tag, "_debug_sig"}, {31'd0, debug_sig}, 32'd0);
  endtask

  task automatic run_frame(input string tag, input bq_t f, input int max_gap);
    got_addr.delete();
    got_instr.delete();
    send_bytes(f, max_gap);
    check_frame(tag, f);
  endtask

  initial begin
    bq_t  f;
    wq_t  w;
    logic [31:0] base, n;
    int   kind;

    #2 nrst = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    nrst   = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);
    check_reset_outputs("idle_after_reset");

    // Two-word program at address 0.
    w = '{32'h00000013, 32'h00100093};
    f = build_frame(32'h0, 32'd2, w);
    run_frame("t1", f, 2);
    check("t1_lit_a1", got_addr.size() > 1 ? got_addr[1] : 32'hDEAD, 32'h4);
    check("t1_lit_w1", got_instr.size() > 1 ? got_instr[1] : 32'hDEAD, 32'h00100093);

    // Empty program: finishes on the last header byte.
    w.delete();
    f = build_frame(32'h1000, 32'd0, w);
    got_addr.delete();
    got_instr.delete();
    send_bytes(f, 0);
    check("t2_done_fast", {31'd0, done}, 32'd1);
    check_frame("t2", f);

    // Misaligned base aborts, then a good frame recovers.
    f = '{8'hA5, 8'h02, 8'h00, 8'h00, 8'h00};
    run_frame("t3_err", f, 1);
    w = '{32'h00000013, 32'h00100093};
    f = build_frame(32'h0, 32'd2, w);
    run_frame("t3_recover", f, 1);

    // Silence inside a frame trips the watchdog exactly 16 cycles later.
    f = '{8'hA5, 8'h00, 8'h00};
    send_bytes(f, 0);
    repeat (15) @(negedge clk);
    check("t4_error_early", {31'd0, error}, 32'd0);
    check("t4_sig_early",   {31'd0, debug_sig}, 32'd1);
    @(negedge clk);
    check("t4_error",     {31'd0, error}, 32'd1);
    check("t4_debug_sig", {31'd0, debug_sig}, 32'd0);
    check("t4_core_nrst", {31'd0, core_nrst}, 32'd0);

    // Back-to-back bytes, three words; MAGIC value inside data is plain data.
    w = '{32'hA5A5A5A5, 32'h12345678, 32'h000000A5};
    f = build_frame(32'h0, 32'd3, w);
    run_frame("t5", f, 0);

    // Address wraps past 2^32.
    w = '{$urandom, $urandom, $urandom, $urandom};
    f = build_frame(32'hFFFFFFF8, 32'd4, w);
    run_frame("wrap", f, 1);

    // Largest legal count, then the first illegal one.
    w.delete();
    for (int i = 0; i < int'(MAXW); i++) w.push_back($urandom);
    f = build_frame(32'h00002000, 32'(MAXW), w);
    run_frame("max_words", f, 0);
    w.delete();
    f = build_frame(32'h0, 32'(MAXW + 1), w);
    f = f[0:8];
    run_frame("over_max", f, 0);

`ifdef DEBUG_LOADER_CHECKSUM_EN
    w = '{32'h00000013, 32'h00100093};
    f = build_frame(32'h0, 32'd2, w);
    f[f.size() - 1] = f[f.size() - 1] ^ 8'h5A;
    run_frame("t6_bad_csum", f, 1);
`endif

    // Reset in the middle of DATA returns everything to reset values.
    f = '{8'hA5, 8'h00, 8'h01, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h37};
    send_bytes(f, 0);
    nrst = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);
    w = '{32'h00000013, 32'h00100093};
    f = build_frame(32'h0, 32'd2, w);
    run_frame("after_reset", f, 1);

    // Randomized frames.
    for (int it = 0; it < 20; it++) begin
      kind = int'($urandom_range(9, 0));
      w.delete();
      if (kind == 0) begin
        base = $urandom;
        if (base[1:0] == 2'b00) base[0] = 1'b1;
        f = build_frame(base, 32'd1, w);
        f = f[0:4];
      end else if (kind == 1) begin
        n = 32'(MAXW + 1) + $urandom_range(100000, 0);
        f = build_frame($urandom & 32'hFFFFFFFC, n, w);
        f = f[0:8];
      end else begin
        n = $urandom_range(5, 0);
        for (int i = 0; i < int'(n); i++) w.push_back($urandom);
        f = build_frame($urandom & 32'hFFFFFFFC, n, w);
      end
      run_frame($sformatf("rnd%0d", it), f, int'($urandom_range(5, 0)));
    end

    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
